dc_offset_ctrl: RTL
===================

// Module: dc_offset_ctrl
// PURPOSE
//  Windowed DC-offset loop controller fed by err_dc_gen's accumulated error.
//  - Counts symbols (clk_en) over 2^WIN_LOG2-symbol windows and captures the window error sum.
//  - Forms the mean error, scales it by the loop gain and integrates it into a saturating DC-offset register.
//  - Pulses acc_clr to restart the accumulator; dc_offset feeds the DC-removal subtractor ahead of the slicer.
// PARAMETERS
//  WIN_LOG2  `LFSR_LEN  log2 of window length N in symbols
//  MU_SHIFT  4          loop gain 2^-MU_SHIFT applied to mean error
//  ACC_LAT   1          clk_en strobes between a sample entering accumulator and appearing on acc_in
//  ACC_W     39         width of acc_in
// PORTS
//  clk        in   1      system clock
//  reset      in   1      asynchronous, active-high reset
//  clk_en     in   1      symbol strobe
//  enable     in   1      loop enable; low freezes dc_offset
//  acc_in     in   ACC_W  signed accumulated error (acc_dc_err_out)
//  acc_clr    out  1      registered 1-clk pulse; drives err_dc_gen reset
//  dc_offset  out  18     signed DC-offset estimate
//  dc_valid   out  1      1-clk pulse when dc_offset updates
//  win_cnt    out  16     completed-window count, wraps at 2^16
// BEHAVIOUR
//  Reset values: state=IDLE, sym_cnt=0, acc_clr=0, dc_offset=0, dc_valid=0, win_cnt=0.
//  States and transitions:
//   IDLE:    enable=1 -> CLEAR.
//   CLEAR:   acc_clr=1 for exactly 1 clk; sym_cnt<=0; -> ACCUM.
//   ACCUM:   each clk_en increments sym_cnt.
//            sym_cnt reaching N+ACC_LAT -> CAPTURE; acc_in then holds the sum of exactly N samples.
//   CAPTURE: acc_q<=acc_in, 1 clk, clk_en ignored; -> UPDATE.
//   UPDATE:  dc_offset<=next; dc_valid=1 for 1 clk; win_cnt++; -> CLEAR.
//  enable=0 in any non-IDLE state:
//   - -> IDLE on the next clk with a single acc_clr pulse.
//   - UPDATE is not performed; dc_offset held; no dc_valid.
//  clk_en strobes in CAPTURE/UPDATE/CLEAR are discarded; they are not counted toward the next window.
//  clk_en and window end in the same clk: the strobe is the last counted one.
//  clk cycles without clk_en have no effect on the window count.
//  Arithmetic, all signed:
//   - mean = acc_q >>> WIN_LOG2 (floor), saturated to 18 bits.
//   - step = mean >>> MU_SHIFT (floor).
//   - next = sat18(dc_offset + step), computed 19 bits wide; limits +131071 / -131072.
//  Latency: window-end strobe -> dc_valid = 2 clk; dc_valid -> acc_clr = 1 clk.
//  Reset asserted mid-operation: all outputs clear asynchronously; restart from IDLE.
// TESTING (bench: WIN_LOG2=4, N=16, MU_SHIFT=2, ACC_LAT=1, err_dc_gen model on acc_in)
//  1) err=+400 constant, enable=1
//     -> dc_valid after every 17th strobe; dc_offset 100, 200, 300; win_cnt 1, 2, 3.
//  2) err=-3 constant -> acc_q=-48, mean=-3, step=-1; dc_offset -1, -2 (floor rounding).
//  3) acc_in forced to +2^38-1 each window -> dc_offset 32767, ..., 131068, then held at 131071.
//     Mirror the test negatively -> held at -131072.
//  4) enable dropped at sym_cnt=7 -> single acc_clr, IDLE, dc_offset unchanged, no dc_valid.
//     Re-enable -> CLEAR, then a full fresh window.
//  5) clk_en every 3rd clk with idle gaps; strobes injected during CAPTURE/UPDATE/CLEAR
//     -> same dc_offset as 1); injected strobes not counted.
//  6) reset pulsed during UPDATE -> dc_offset=0, dc_valid=0, win_cnt=0 immediately; next window starts only after CLEAR.

Source files
------------

// File: rtl/dc_offset_ctrl.sv
// Windowed DC-offset loop controller: counts symbol windows, captures the accumulated
// error, and integrates the gain-scaled mean error into a saturating 18-bit offset.
`ifndef LFSR_LEN
`define LFSR_LEN 4
`endif

module dc_offset_ctrl #(
    parameter int WIN_LOG2 = `LFSR_LEN,
    parameter int MU_SHIFT = 4,
    parameter int ACC_LAT  = 1,
    parameter int ACC_W    = 39
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    enable,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic                    acc_clr,
    output logic signed [17:0]      dc_offset,
    output logic                    dc_valid,
    output logic [15:0]             win_cnt
);

    localparam int N       = 1 << WIN_LOG2;
    localparam int WIN_END = N + ACC_LAT;
    localparam int CNT_W   = $clog2(WIN_END + 1);

    localparam logic signed [ACC_W-1:0] MEAN_MAX = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] MEAN_MIN = ACC_W'(-131072);
    localparam logic signed [17:0]      DC_MAX   = 18'sh1FFFF;
    localparam logic signed [17:0]      DC_MIN   = 18'sh20000;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        CAPTURE,
        UPDATE
    } state_t;

    state_t                    state_q,     state_d;
    logic [CNT_W-1:0]          sym_cnt_q,   sym_cnt_d;
    logic signed [ACC_W-1:0]   acc_q,       acc_d;
    logic signed [17:0]        dc_offset_q, dc_offset_d;
    logic                      dc_valid_q,  dc_valid_d;
    logic                      acc_clr_q,   acc_clr_d;
    logic [15:0]               win_cnt_q,   win_cnt_d;

    logic signed [ACC_W-1:0]   mean_full;
    logic signed [17:0]        mean_sat;
    logic signed [17:0]        step;
    logic signed [18:0]        sum_ext;
    logic signed [17:0]        dc_next;

    always_comb begin
        mean_full = acc_q >>> WIN_LOG2;
        if (mean_full > MEAN_MAX) begin
            mean_sat = DC_MAX;
        end else if (mean_full < MEAN_MIN) begin
            mean_sat = DC_MIN;
        end else begin
            mean_sat = mean_full[17:0];
        end
        step    = mean_sat >>> MU_SHIFT;
        sum_ext = {dc_offset_q[17], dc_offset_q} + {step[17], step};
        if (sum_ext[18] != sum_ext[17]) begin
            dc_next = sum_ext[18] ? DC_MIN : DC_MAX;
        end else begin
            dc_next = sum_ext[17:0];
        end
    end

    // The cycle in which acc_clr is high is still a clear cycle for the accumulator,
    // so strobes landing there are not counted either.
    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        acc_d       = acc_q;
        dc_offset_d = dc_offset_q;
        dc_valid_d  = 1'b0;
        acc_clr_d   = 1'b0;
        win_cnt_d   = win_cnt_q;

        if (state_q != IDLE && !enable) begin
            state_d   = IDLE;
            sym_cnt_d = '0;
            acc_clr_d = !acc_clr_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    acc_clr_d = 1'b1;
                    sym_cnt_d = '0;
                    state_d   = ACCUM;
                end
                ACCUM: begin
                    if (clk_en && !acc_clr_q) begin
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                        if (sym_cnt_q == CNT_W'(WIN_END - 1)) begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    acc_d   = acc_in;
                    state_d = UPDATE;
                end
                UPDATE: begin
                    dc_offset_d = dc_next;
                    dc_valid_d  = 1'b1;
                    win_cnt_d   = win_cnt_q + 16'd1;
                    state_d     = CLEAR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sym_cnt_q   <= '0;
            acc_q       <= '0;
            dc_offset_q <= '0;
            dc_valid_q  <= 1'b0;
            acc_clr_q   <= 1'b0;
            win_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            acc_q       <= acc_d;
            dc_offset_q <= dc_offset_d;
            dc_valid_q  <= dc_valid_d;
            acc_clr_q   <= acc_clr_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    assign acc_clr   = acc_clr_q;
    assign dc_offset = dc_offset_q;
    assign dc_valid  = dc_valid_q;
    assign win_cnt   = win_cnt_q;

endmodule
